// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM encoding
// and the baud divisor helper used by both transmitter and receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Rounded to the nearest integer so the baud error stays within half a clock.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period divider: tick is high on the last cycle of each
// period while enabled; clear restarts the period from zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
  end

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = enable && !clear && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised RS-232 transmitter with valid/ready intake; data is latched on
// acceptance so the source may change tx_data for the rest of the frame.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_divisor
    $error("uart_tx_param: CLK_FREQ/BAUD must give at least 2 clocks per bit");
  end

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_parity;
  logic       r_txd;
  logic       r_done;

  logic       w_accept;
  logic       w_tick;
  logic [7:0] w_data;

  assign tx_ready = (r_state == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = r_done;
  assign txd      = r_txd;

  assign w_accept = tx_valid && tx_ready;
  assign w_data   = tx_data & DATA_MASK;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_accept),
    .enable(r_state != ST_IDLE),
    .tick  (w_tick)
  );

  // NOTE: the shift register is a handful of flops, not a memory, so it is
  // reset along with the rest of the datapath to give a known power-up image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_txd     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // NOTE: the default arm keeps the case full; in a clocked block an
      // unlisted state just holds, but it is forced back to IDLE for recovery.
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (w_accept) begin
            r_shift   <= w_data;
            r_parity  <= (PARITY == PARITY_ODD) ? ~^w_data : ^w_data;
            r_bit_cnt <= '0;
            r_txd     <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                r_txd   <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              r_done    <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets share one clock and
// reset; expected line bits are queued at acceptance and popped mid-bit.
module tb_uart_tx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       tx_busy  [4];
  logic       tx_done  [4];
  logic       txd      [4];

  // Per-instance configuration, mirrored in the instantiations below.
  int cfg_bits   [4] = '{8, 8, 8, 7};
  int cfg_parity [4] = '{0, 2, 1, 0};
  int cfg_stop   [4] = '{1, 1, 1, 2};

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .txd(txd[0]));
  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .txd(txd[1]));
  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .txd(txd[2]));
  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]), .txd(txd[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for ready, presents data, and checks the whole frame bit by bit.
  task automatic run_frame(input int idx, input logic [7:0] data, input logic [7:0] data_after,
                           input bit hold_valid, output int waited);
    int ones;
    int f;
    waited = 0;
    while (tx_ready[idx] !== 1'b1 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_wait_bound", waited < 1000, 1'b1);
    tx_data[idx]  = data;
    tx_valid[idx] = 1'b1;
    @(posedge clk); #1;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int b = 0; b < cfg_bits[idx]; b++) begin
      exp_q.push_back(data[b]);
      ones += int'(data[b]);
    end
    if (cfg_parity[idx] == 2) exp_q.push_back(ones % 2 == 1);
    if (cfg_parity[idx] == 1) exp_q.push_back(ones % 2 == 0);
    for (int s = 0; s < cfg_stop[idx]; s++) exp_q.push_back(1'b1);
    f = CPB * exp_q.size();
    tx_data[idx]  = data_after;
    tx_valid[idx] = hold_valid;
    check("ready_after_accept", tx_ready[idx], 1'b0);
    check("start_edge_txd", txd[idx], 1'b0);
    for (int cyc = 1; cyc <= f; cyc++) begin
      @(posedge clk); #1;
      if (cyc % CPB == CPB / 2) begin
        check("txd_bit", txd[idx], exp_q.pop_front());
        check("ready_in_frame", tx_ready[idx], 1'b0);
        check("busy_in_frame", tx_busy[idx], 1'b1);
        check("done_in_frame", tx_done[idx], 1'b0);
      end
      if (cyc == f - 1) begin
        check("done_before_end", tx_done[idx], 1'b0);
        check("ready_before_end", tx_ready[idx], 1'b0);
      end
      if (cyc == f) begin
        check("done_at_end", tx_done[idx], 1'b1);
        check("ready_at_end", tx_ready[idx], 1'b1);
        check("busy_at_end", tx_busy[idx], 1'b0);
        check("txd_idle_at_end", txd[idx], 1'b1);
      end
    end
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_txd", txd[i], 1'b1);
      check("reset_ready", tx_ready[i], 1'b1);
      check("reset_busy", tx_busy[i], 1'b0);
      check("reset_done", tx_done[i], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // 8N1 with 0x53, then even and odd parity, then 7 data bits with 2 stops.
    run_frame(0, 8'h53, 8'h53, 1'b0, w);
    run_frame(1, 8'h53, 8'h53, 1'b0, w);
    run_frame(2, 8'h53, 8'h53, 1'b0, w);
    run_frame(3, 8'hD3, 8'hD3, 1'b0, w);

    // Back-to-back with tx_valid held: second frame must start one cycle after done.
    run_frame(0, 8'h00, 8'hFF, 1'b1, w);
    run_frame(0, 8'hFF, 8'h11, 1'b0, w);
    check("b2b_idle_gap", w, 0);

    // Reset in the middle of a frame.
    tx_data[0]  = 8'h53;
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    check("mid_rst_frame_started", tx_ready[0], 1'b0);
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_async_txd", txd[0], 1'b1);
    check("mid_rst_async_ready", tx_ready[0], 1'b1);
    check("mid_rst_async_busy", tx_busy[0], 1'b0);
    check("mid_rst_done", tx_done[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", tx_done[0], 1'b0);
      check("post_rst_txd_idle", txd[0], 1'b1);
    end
    run_frame(0, 8'hA5, 8'h00, 1'b0, w);

    // Long idle after reset: line stays high, no activity.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        check("idle_txd_ready_done", {txd[i], tx_ready[i], tx_done[i]}, 3'b110);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
